i2c_target_core: RTL and testbench

Synthesizable, parametrised I2C target (slave) controller: the RTL successor to the bus-functional I2C slave used on the bench. It samples the open-drain SCL/SDA lines on the system clock, detects START/repeated-START/STOP, and matches a programmable address. Write bytes go into an internal RX FIFO; read bytes come from a valid/ready TX stream. It sits between the board-level I2C pads and the register/DMA logic of the peripheral.

---
 rtl/i2c_target_core.sv | 207 ++++++++++++++++++++
 tb/tb_i2c_target_core.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_core.sv
// i2c_target_core: I2C target with address match, RX FIFO and valid/ready TX stream.
// Define I2C_TARGET_CLK_STRETCH_EN to stretch SCL on TX underrun or full RX FIFO.
module i2c_target_core #(
  parameter int ADDR_WIDTH  = 7,
  parameter int DATA_WIDTH  = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  scl_i,
  input  logic                  sda_i,
  output logic                  scl_oe_o,
  output logic                  sda_oe_o,
  input  logic [ADDR_WIDTH-1:0] own_addr_i,
  output logic [DATA_WIDTH-1:0] rx_data_o,
  output logic                  rx_valid_o,
  input  logic                  rx_ready_i,
  input  logic [DATA_WIDTH-1:0] tx_data_i,
  input  logic                  tx_valid_i,
  output logic                  tx_ready_o,
  output logic                  busy_o,
  output logic                  rw_o,
  output logic                  start_o,
  output logic                  stop_o,
  output logic                  match_o,
  output logic                  overflow_o,
  output logic                  nack_o
);
`ifdef I2C_TARGET_CLK_STRETCH_EN
  localparam bit STRETCH = 1'b1;
`else
  localparam bit STRETCH = 1'b0;
`endif
  localparam int SW = (ADDR_WIDTH + 1 > DATA_WIDTH) ? ADDR_WIDTH + 1 : DATA_WIDTH;
  localparam int CW = $clog2(SW + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  typedef enum logic [3:0] {IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_LOAD, RD_DATA, RD_ACK, IGNORE} state_t;
  state_t state;
  logic [SYNC_STAGES-1:0] scl_s, sda_s;
  logic [1:0] scl_h, sda_h;
  logic scl_f, sda_f, scl_p, sda_p;
  logic rise, fall, start_c, stop_c;
  logic [SW-1:0] sh;
  logic [CW-1:0] cnt;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wp, rp;
  logic [PW:0] count;
  logic push, pop, space;
  function automatic logic maj(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction
  // Synchroniser, then a 3-sample majority vote; idle bus reads high.
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      scl_s <= '1;
      sda_s <= '1;
      scl_h <= '1;
      sda_h <= '1;
      {scl_f, sda_f, scl_p, sda_p} <= '1;
    end else begin
      scl_s <= {scl_s[SYNC_STAGES-2:0], scl_i};
      sda_s <= {sda_s[SYNC_STAGES-2:0], sda_i};
      scl_h <= {scl_h[0], scl_s[SYNC_STAGES-1]};
      sda_h <= {sda_h[0], sda_s[SYNC_STAGES-1]};
      scl_f <= maj(scl_s[SYNC_STAGES-1], scl_h[0], scl_h[1]);
      sda_f <= maj(sda_s[SYNC_STAGES-1], sda_h[0], sda_h[1]);
      scl_p <= scl_f;
      sda_p <= sda_f;
    end
  assign rise    = scl_f & ~scl_p;
  assign fall    = ~scl_f & scl_p;
  assign start_c = scl_f & scl_p & sda_p & ~sda_f;
  assign stop_c  = scl_f & scl_p & ~sda_p & sda_f;
  assign rx_valid_o = |count;
  assign rx_data_o  = mem[rp];
  assign pop   = rx_valid_o & rx_ready_i;
  assign space = count != (PW+1)'(FIFO_DEPTH) || pop;
  assign push  = state == WR_DATA && cnt == CW'(DATA_WIDTH) && !scl_f && space;
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (push) mem[wp] <= sh[DATA_WIDTH-1:0];
      wp <= wp + PW'(push);
      rp <= rp + PW'(pop);
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      state <= IDLE;
      sh <= '0;
      cnt <= '0;
      addr <= '0;
      {scl_oe_o, sda_oe_o, tx_ready_o, busy_o, rw_o} <= '0;
      {start_o, stop_o, match_o, overflow_o, nack_o} <= '0;
    end else begin
      {start_o, stop_o, match_o, overflow_o, nack_o} <= '0;
      if (stop_c) begin
        stop_o <= 1'b1;
        state <= IDLE;
        busy_o <= 1'b0;
        {scl_oe_o, sda_oe_o, tx_ready_o} <= '0;
      end else if (start_c) begin
        start_o <= 1'b1;
        state <= ADDR;
        cnt <= '0;
        addr <= own_addr_i;
        {scl_oe_o, sda_oe_o, tx_ready_o} <= '0;
      end else
        case (state)
          ADDR:
            if (rise) begin
              sh <= {sh[SW-2:0], sda_f};
              cnt <= cnt + CW'(1);
            end else if (cnt == CW'(ADDR_WIDTH + 1) && !scl_f) begin
              if (sh[ADDR_WIDTH:1] == addr) begin
                match_o <= 1'b1;
                sda_oe_o <= 1'b1;
                busy_o <= 1'b1;
                rw_o <= sh[0];
                state <= ADDR_ACK;
              end else begin
                busy_o <= 1'b0;
                state <= IGNORE;
              end
            end
          ADDR_ACK:
            if (fall) begin
              sda_oe_o <= 1'b0;
              cnt <= '0;
              tx_ready_o <= rw_o;
              scl_oe_o <= STRETCH & rw_o & ~tx_valid_i;
              state <= rw_o ? RD_LOAD : WR_DATA;
            end
          WR_DATA:
            if (rise) begin
              sh <= {sh[SW-2:0], sda_f};
              cnt <= cnt + CW'(1);
            end else if (cnt == CW'(DATA_WIDTH) && !scl_f) begin
              if (space) begin
                sda_oe_o <= 1'b1;
                scl_oe_o <= 1'b0;
                state <= WR_ACK;
              end else if (STRETCH)
                scl_oe_o <= 1'b1;
              else begin
                overflow_o <= 1'b1;
                state <= WR_ACK;
              end
            end
          WR_ACK:
            if (fall) begin
              sda_oe_o <= 1'b0;
              cnt <= '0;
              state <= WR_DATA;
            end
          RD_LOAD:
            if (tx_ready_o && tx_valid_i) begin
              sh <= SW'(tx_data_i);
              sda_oe_o <= ~tx_data_i[DATA_WIDTH-1];
              cnt <= '0;
              {tx_ready_o, scl_oe_o} <= '0;
              state <= RD_DATA;
            end else if (rise && !STRETCH) begin
              // Master clocked bit 7 with nothing loaded: send all-ones.
              sh <= '1;
              cnt <= CW'(1);
              tx_ready_o <= 1'b0;
              overflow_o <= 1'b1;
              state <= RD_DATA;
            end else begin
              tx_ready_o <= 1'b1;
              scl_oe_o <= STRETCH & ~tx_valid_i;
            end
          RD_DATA:
            if (rise)
              cnt <= cnt + CW'(1);
            else if (fall) begin
              if (cnt == CW'(DATA_WIDTH)) begin
                sda_oe_o <= 1'b0;
                state <= RD_ACK;
              end else begin
                sh <= sh << 1;
                sda_oe_o <= ~sh[DATA_WIDTH-2];
              end
            end
          RD_ACK:
            if (rise) begin
              if (sda_f) begin
                nack_o <= 1'b1;
                state <= IGNORE;
              end else
                cnt <= '0;
            end else if (fall && cnt == '0) begin
              tx_ready_o <= 1'b1;
              scl_oe_o <= STRETCH & ~tx_valid_i;
              state <= RD_LOAD;
            end
          default: ;
        endcase
    end
endmodule

// File: tb/tb_i2c_target_core.sv
// tb_i2c_target_core: bit-banged I2C master against i2c_target_core with a queue model of the RX FIFO.
module tb_i2c_target_core;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic rst_n;
  logic scl_m, sda_m, scl, sda;
  logic scl_oe, sda_oe;
  logic [6:0] own_addr;
  logic [7:0] rx_data, tx_data;
  logic rx_valid, rx_ready, tx_valid, tx_ready;
  logic busy, rw, start_p, stop_p, match_p, ovf_p, nack_p;
  int errors = 0, checks = 0;
  int n_start = 0, n_stop = 0, n_match = 0, n_ovf = 0, n_nack = 0, n_hs = 0, n_sdaoe = 0;
  always #5 clk = ~clk;
  assign scl = scl_m & ~scl_oe;
  assign sda = sda_m & ~sda_oe;
  i2c_target_core dut (
    .clk_i(clk), .rst_n_i(rst_n), .scl_i(scl), .sda_i(sda),
    .scl_oe_o(scl_oe), .sda_oe_o(sda_oe), .own_addr_i(own_addr),
    .rx_data_o(rx_data), .rx_valid_o(rx_valid), .rx_ready_i(rx_ready),
    .tx_data_i(tx_data), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready),
    .busy_o(busy), .rw_o(rw), .start_o(start_p), .stop_o(stop_p),
    .match_o(match_p), .overflow_o(ovf_p), .nack_o(nack_p)
  );
  // Pulse and handshake counters, sampled mid-cycle.
  always @(negedge clk) begin
    n_start += int'(start_p);
    n_stop  += int'(stop_p);
    n_match += int'(match_p);
    n_ovf   += int'(ovf_p);
    n_nack  += int'(nack_p);
    n_hs    += int'(tx_ready && tx_valid);
    n_sdaoe += int'(sda_oe);
  end
  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic i2c_start();
    sda_m = 1'b1; wait_clk(10); scl_m = 1'b1; wait_clk(20);
    sda_m = 1'b0; wait_clk(20); scl_m = 1'b0; wait_clk(10);
  endtask
  task automatic i2c_stop();
    sda_m = 1'b0; wait_clk(10); scl_m = 1'b1; wait_clk(20);
    sda_m = 1'b1; wait_clk(20);
  endtask
  task automatic bit_w(input logic b);
    sda_m = b; wait_clk(10); scl_m = 1'b1; wait_clk(20); scl_m = 1'b0; wait_clk(10);
  endtask
  task automatic bit_r(output logic b);
    sda_m = 1'b1; wait_clk(10); scl_m = 1'b1; wait_clk(10);
    b = sda; wait_clk(10); scl_m = 1'b0; wait_clk(10);
  endtask
  task automatic byte_w(input logic [7:0] d, output logic ack);
    logic a;
    for (int i = 7; i >= 0; i--) bit_w(d[i]);
    bit_r(a);
    ack = ~a;
  endtask
  task automatic byte_r(output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      bit_r(b);
      d[i] = b;
    end
  endtask
  task automatic pop();
    rx_ready = 1'b1; wait_clk(1); rx_ready = 1'b0; wait_clk(1);
  endtask
  initial begin
    logic ack, exp_ack, b;
    logic [7:0] d, d2, q_head;
    logic [6:0] a, a2;
    logic [7:0] q[$];
    int s_start, s_stop, s_match, s_ovf, s_nack, s_hs, s_oe, nacks;
    rst_n = 1'b0; scl_m = 1'b1; sda_m = 1'b1; own_addr = 7'h50;
    rx_ready = 1'b0; tx_data = 8'h00; tx_valid = 1'b0;
    wait_clk(5);
    check("rst_scl_oe", scl_oe, 0);
    check("rst_sda_oe", sda_oe, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_tx_ready", tx_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_rw", rw, 0);
    check("rst_pulses", {start_p, stop_p, match_p, ovf_p, nack_p}, 0);
    rst_n = 1'b1;
    wait_clk(20);
    // Plain write of two bytes.
    s_start = n_start; s_stop = n_stop; s_match = n_match;
    i2c_start();
    byte_w(8'hA0, ack); check("wr_addr_ack", ack, 1);
    check("wr_busy", busy, 1);
    byte_w(8'hA5, ack); check("wr_d0_ack", ack, 1);
    byte_w(8'h3C, ack); check("wr_d1_ack", ack, 1);
    i2c_stop(); wait_clk(5);
    check("wr_start_cnt", n_start - s_start, 1);
    check("wr_stop_cnt", n_stop - s_stop, 1);
    check("wr_match_cnt", n_match - s_match, 1);
    check("wr_busy_after", busy, 0);
    check("wr_rx_valid", rx_valid, 1);
    check("wr_rx0", rx_data, 8'hA5); pop();
    check("wr_rx1", rx_data, 8'h3C); pop();
    check("wr_rx_empty", rx_valid, 0);
    // Address mismatch: target must stay silent.
    s_match = n_match; s_oe = n_sdaoe;
    i2c_start();
    byte_w(8'hA2, ack); check("mis_addr_ack", ack, 0);
    byte_w(8'($urandom), ack); check("mis_data_ack", ack, 0);
    i2c_stop(); wait_clk(5);
    check("mis_match_cnt", n_match - s_match, 0);
    check("mis_sda_driven", n_sdaoe - s_oe, 0);
    check("mis_rx_valid", rx_valid, 0);
    // Random bytes into a FIFO nobody drains: ACK while room, NACK + overflow after.
    s_ovf = n_ovf; nacks = 0;
    i2c_start();
    byte_w(8'hA0, ack); check("ovf_addr_ack", ack, 1);
    for (int i = 0; i < 6; i++) begin
      d = 8'($urandom);
      exp_ack = q.size() < DEPTH;
      byte_w(d, ack);
      if (exp_ack) q.push_back(d); else nacks++;
      check($sformatf("ovf_ack%0d", i), ack, exp_ack);
    end
    i2c_stop(); wait_clk(5);
    check("ovf_pulses", n_ovf - s_ovf, nacks);
    while (q.size() > 0) begin
      q_head = q.pop_front();
      check("ovf_rx_data", rx_data, q_head);
      pop();
    end
    check("ovf_rx_empty", rx_valid, 0);
    // Read two random bytes, master NACKs the second.
    s_nack = n_nack; s_hs = n_hs;
    d = 8'($urandom); d2 = 8'($urandom);
    tx_data = d; tx_valid = 1'b1;
    i2c_start();
    byte_w(8'hA1, ack); check("rd_addr_ack", ack, 1);
    check("rd_rw", rw, 1);
    byte_r(q_head); check("rd_byte0", q_head, d);
    tx_data = d2; bit_w(1'b0);
    byte_r(q_head); check("rd_byte1", q_head, d2);
    bit_w(1'b1);
    check("rd_nack_cnt", n_nack - s_nack, 1);
    check("rd_sda_released", sda_oe, 0);
    i2c_stop(); wait_clk(5);
    check("rd_loads", n_hs - s_hs, 2);
    tx_valid = 1'b0;
    // Write, repeated START, read.
    s_start = n_start; d = 8'($urandom);
    i2c_start();
    byte_w(8'hA0, ack); check("rs_wr_ack", ack, 1);
    check("rs_rw0", rw, 0);
    byte_w(8'h07, ack); check("rs_data_ack", ack, 1);
    sda_m = 1'b1; wait_clk(10); scl_m = 1'b1; wait_clk(20);
    sda_m = 1'b0; wait_clk(20); scl_m = 1'b0; wait_clk(10);
    check("rs_busy_held", busy, 1);
    tx_data = d; tx_valid = 1'b1;
    byte_w(8'hA1, ack); check("rs_rd_ack", ack, 1);
    check("rs_rw1", rw, 1);
    byte_r(q_head); check("rs_rd_byte", q_head, d);
    bit_w(1'b1);
    check("rs_busy_pre_stop", busy, 1);
    i2c_stop(); wait_clk(5);
    tx_valid = 1'b0;
    check("rs_start_cnt", n_start - s_start, 2);
    check("rs_busy_after", busy, 0);
    check("rs_rx", rx_data, 8'h07); pop();
    // Read with no TX data available: all-ones byte plus overflow pulse.
    s_ovf = n_ovf;
    i2c_start();
    byte_w(8'hA1, ack); check("un_addr_ack", ack, 1);
    byte_r(q_head); check("un_byte", q_head, 8'hFF);
    bit_w(1'b1);
    i2c_stop(); wait_clk(5);
    check("un_ovf_cnt", n_ovf - s_ovf, 1);
    // Random own addresses, matching and single-bit-off.
    for (int k = 0; k < 3; k++) begin
      a = 7'($urandom_range(0, 127));
      a2 = a ^ (7'h1 << $urandom_range(0, 6));
      d = 8'($urandom);
      own_addr = a;
      i2c_start();
      byte_w({a, 1'b0}, ack); check("ra_match_ack", ack, 1);
      byte_w(d, ack); check("ra_data_ack", ack, 1);
      i2c_stop(); wait_clk(5);
      check("ra_rx", rx_data, d); pop();
      i2c_start();
      byte_w({a2, 1'b0}, ack); check("ra_miss_ack", ack, 0);
      i2c_stop(); wait_clk(5);
    end
    check("ra_rx_empty", rx_valid, 0);
    // Reset while the target drives data bit 4 of a read.
    own_addr = 7'h50;
    i2c_start();
    byte_w(8'hA0, ack); byte_w(8'($urandom), ack); check("rr_pre_ack", ack, 1);
    i2c_stop(); wait_clk(5);
    check("rr_pre_valid", rx_valid, 1);
    tx_data = 8'h00; tx_valid = 1'b1;
    i2c_start();
    byte_w(8'hA1, ack); check("rr_addr_ack", ack, 1);
    for (int i = 0; i < 3; i++) begin
      bit_r(b);
      check("rr_bit", b, 0);
    end
    sda_m = 1'b1; wait_clk(10); scl_m = 1'b1; wait_clk(5);
    check("rr_driving", sda_oe, 1);
    #1 rst_n = 1'b0;
    #1;
    check("rr_sda_oe", sda_oe, 0);
    check("rr_scl_oe", scl_oe, 0);
    check("rr_busy", busy, 0);
    check("rr_rx_valid", rx_valid, 0);
    check("rr_tx_ready", tx_ready, 0);
    wait_clk(5);
    tx_valid = 1'b0;
    rst_n = 1'b1;
    wait_clk(20);
    // Recovery after reset.
    d = 8'($urandom);
    i2c_start();
    byte_w(8'hA0, ack); check("rec_addr_ack", ack, 1);
    byte_w(d, ack); check("rec_data_ack", ack, 1);
    i2c_stop(); wait_clk(5);
    check("rec_rx", rx_data, d); pop();
    check("rec_busy", busy, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
